// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 4800,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t          state, state_n;
    logic [3:0]      rows_m, rows_s;
    logic [1:0]      ci, ci_n;
    logic [1:0]      ri, ri_n;
    logic [DW-1:0]   dwell, dwell_n;
    logic [BW-1:0]   deb, deb_n;
    logic [3:0]      code_n;
    logic            valid_n;
    logic            held_n;
    logic            row_up;

    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0])      lowest_low = 2'd0;
        else if (!r[1]) lowest_low = 2'd1;
        else if (!r[2]) lowest_low = 2'd2;
        else            lowest_low = 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'hE;
            4'b11_01: key_map = 4'h0;
            4'b11_10: key_map = 4'hF;
            default:  key_map = 4'hD;
        endcase
    endfunction

    // Only the latched row is ever examined once a key is locked
    assign row_up = rows_s[ri];

    always_comb begin
        state_n = state;
        ci_n    = ci;
        ri_n    = ri;
        dwell_n = '0;
        deb_n   = (deb == DEB_LAST) ? deb : deb + BW'(1);
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
        case (state)
            S_SCAN: begin
                deb_n = '0;
                if (dwell == DWELL_LAST) begin
                    if (rows_s != 4'hF) begin
                        ri_n    = lowest_low(rows_s);
                        state_n = S_DEBOUNCE;
                    end else begin
                        ci_n = ci + 2'd1;
                    end
                end else begin
                    dwell_n = dwell + DW'(1);
                end
            end
            S_DEBOUNCE: begin
                if (row_up)
                    state_n = S_SCAN;
                else if (deb == DEB_LAST)
                    state_n = S_PRESSED;
            end
            S_PRESSED: begin
                code_n  = key_map(ri, ci);
                valid_n = 1'b1;
                held_n  = 1'b1;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                deb_n = '0;
                if (row_up)
                    state_n = S_RELEASE;
            end
            S_RELEASE: begin
                if (!row_up) begin
                    deb_n   = '0;
                    state_n = S_HOLD;
                end else if (deb == DEB_LAST) begin
                    held_n  = 1'b0;
                    ci_n    = ci + 2'd1;
                    state_n = S_SCAN;
                end
            end
            default: state_n = S_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_SCAN;
            rows_m    <= 4'hF;
            rows_s    <= 4'hF;
            ci        <= 2'd0;
            ri        <= 2'd0;
            dwell     <= '0;
            deb       <= '0;
            cols      <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            rows_m    <= rows;
            rows_s    <= rows_m;
            ci        <= ci_n;
            ri        <= ri_n;
            dwell     <= dwell_n;
            deb       <= deb_n;
            cols      <= ~(4'b0001 << ci_n);
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a physical keypad model
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    logic        prev_valid = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed switch pulls its row low only while its column is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic logic [3:0] col_drv(input int c);
        col_drv = ~(4'b0001 << c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            total++;
            if (prev_valid) begin
                bad++;
                $display("FAIL valid_width: got 2+ cycles expected 1");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got code %0h expected no key_valid", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp) begin
                    bad++;
                    $display("FAIL key_code: got %0h expected %0h", key_code, mon_exp);
                end
            end
        end
        prev_valid = key_valid;
    end

    task automatic do_press(input int r, input int r2, input int c,
                            input int nbp, input int nbr, input bit distract);
        logic [15:0] keys;
        int n;
        int dr, dc, rlo;
        keys = '0;
        keys[r*4+c]  = 1'b1;
        keys[r2*4+c] = 1'b1;
        rlo = (r < r2) ? r : r2;
        exp_q.push_back(kmap[rlo*4+c]);
        for (int i = 0; i < nbp; i++) begin
            pressed = pressed | keys;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            pressed = pressed & ~keys;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        pressed = pressed | keys;
        n = 0;
        while (!key_held && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("press_seen", 32'(key_held), 32'd1);
        chk("hold_cols", 32'(cols), 32'(col_drv(c)));
        if (distract) begin
            dc = (c + 1 + int'($urandom_range(0, 2))) % 4;
            dr = int'($urandom_range(0, 3));
            pressed[dr*4+dc] = 1'b1;
            repeat ($urandom_range(3, 10)) @(negedge clk);
            chk("hold_ignores_other", 32'(cols), 32'(col_drv(c)));
            pressed[dr*4+dc] = 1'b0;
        end
        repeat ($urandom_range(2, 20)) @(negedge clk);
        for (int i = 0; i < nbr; i++) begin
            pressed = pressed & ~keys;
            @(negedge clk);
            pressed = pressed | keys;
            @(negedge clk);
        end
        pressed = pressed & ~keys;
        n = 0;
        while (key_held && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("release_latency", 32'(n), 32'(DEB + 3));
        chk("resume_col", 32'(cols), 32'(col_drv((c + 1) % 4)));
        repeat ($urandom_range(2, 8)) @(negedge clk);
    endtask

    initial begin
        int rr, rr2, cc;
        reset   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cols", 32'(cols), 32'h0000000E);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);

        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            chk("idle_cols", 32'(cols), 32'(col_drv((k / 4) % 4)));
        end

        // clean press of key 5 held from reset exit
        @(negedge clk) reset = 1'b0;
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 2 * SCAN + DEB + 1; k++) begin
            @(negedge clk);
            if (k == 2 * SCAN + DEB) begin
                chk("k5_valid_early", 32'(key_valid), 32'd0);
                chk("k5_held_early", 32'(key_held), 32'd0);
            end
            if (k == 2 * SCAN + DEB + 1) begin
                chk("k5_valid_edge", 32'(key_valid), 32'd1);
                chk("k5_held_edge", 32'(key_held), 32'd1);
                chk("k5_code", 32'(key_code), 32'h5);
                chk("k5_cols", 32'(cols), 32'h0000000D);
            end
        end
        repeat (31) @(negedge clk);
        pressed = '0;
        for (int k = 1; k <= DEB + 3; k++) begin
            @(negedge clk);
            if (k == DEB + 2) chk("k5_held_before_fall", 32'(key_held), 32'd1);
            if (k == DEB + 3) begin
                chk("k5_held_fall", 32'(key_held), 32'd0);
                chk("k5_resume_col2", 32'(cols), 32'h0000000B);
            end
        end

        // reset in the middle of HOLD
        @(negedge clk) reset = 1'b0;
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        @(negedge clk) reset = 1'b1;
        repeat (2 * SCAN + DEB + 6) @(negedge clk);
        chk("hold_before_rst", 32'(key_held), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_hold_cols", 32'(cols), 32'h0000000E);
        chk("rst_hold_held", 32'(key_held), 32'd0);
        chk("rst_hold_valid", 32'(key_valid), 32'd0);
        chk("rst_hold_code", 32'(key_code), 32'd0);
        pressed = '0;
        @(negedge clk) reset = 1'b1;
        repeat (10) @(negedge clk);

        // reset in the middle of DEBOUNCE
        @(negedge clk) reset = 1'b0;
        pressed[1*4+1] = 1'b1;
        @(negedge clk) reset = 1'b1;
        repeat (2 * SCAN + 7) @(negedge clk);
        chk("deb_cols_frozen", 32'(cols), 32'h0000000D);
        reset = 1'b0;
        #1;
        chk("rst_deb_cols", 32'(cols), 32'h0000000E);
        chk("rst_deb_held", 32'(key_held), 32'd0);
        chk("rst_deb_valid", 32'(key_valid), 32'd0);
        pressed = '0;
        @(negedge clk) reset = 1'b1;
        repeat (40) @(negedge clk);

        do_press(0, 2, 2, 0, 0, 1'b1);
        do_press(0, 0, 3, 4, 0, 1'b0);
        do_press(3, 3, 1, 0, 3, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rr  = int'($urandom_range(0, 3));
            rr2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : rr;
            cc  = int'($urandom_range(0, 3));
            do_press(rr, rr2, cc, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
